// File: rtl/lc3_mem_arbiter.sv
// Arbitrates one single-port memory between the LC3 fetch and data ports.
// Data has priority; fetch is forced through after STARVE_MAX data grants.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instrmem_rd,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0] instr_dout_q, instr_dout_d;
  logic [DATA_W-1:0] data_dout_q, data_dout_d;
  logic              complete_instr_q, complete_instr_d;
  logic              complete_data_q, complete_data_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              bus_err_q, bus_err_d;

  logic busy, ack_done, expire, finish, grant_data, grant_instr;

  assign busy        = (state_q != IDLE);
  assign ack_done    = busy && mem_ack;
  // Ack in the expiry cycle takes precedence over the timeout.
  assign expire      = busy && !mem_ack && (wait_q == TW'(TIMEOUT - 1));
  assign finish      = ack_done || expire;
  assign grant_data  = data_req && !(instrmem_rd && (starve_q == SW'(STARVE_MAX)));
  assign grant_instr = !grant_data && instrmem_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      starve_q         <= '0;
      wait_q           <= '0;
      instr_dout_q     <= '0;
      data_dout_q      <= '0;
      complete_instr_q <= 1'b0;
      complete_data_q  <= 1'b0;
      mem_en_q         <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      bus_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      starve_q         <= starve_d;
      wait_q           <= wait_d;
      instr_dout_q     <= instr_dout_d;
      data_dout_q      <= data_dout_d;
      complete_instr_q <= complete_instr_d;
      complete_data_q  <= complete_data_d;
      mem_en_q         <= mem_en_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      bus_err_q        <= bus_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (!instrmem_rd) starve_d = '0;
        if (grant_data) begin
          state_d = DATA;
          if (instrmem_rd && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
        end else if (grant_instr) begin
          state_d  = INSTR;
          starve_d = '0;
        end
      end
      default: begin
        if (finish) begin
          state_d = IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
    endcase
  end

  always_comb begin
    instr_dout_d     = instr_dout_q;
    data_dout_d      = data_dout_q;
    complete_instr_d = 1'b0;
    complete_data_d  = 1'b0;
    mem_en_d         = mem_en_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    bus_err_d        = 1'b0;
    if (state_q == IDLE) begin
      if (grant_data) begin
        mem_en_d    = 1'b1;
        mem_we_d    = !Data_rd;
        mem_addr_d  = Data_addr;
        mem_wdata_d = Data_din;
      end else if (grant_instr) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = pc;
        mem_wdata_d = '0;
      end
    end else if (finish) begin
      mem_en_d  = 1'b0;
      mem_we_d  = 1'b0;
      bus_err_d = expire;
      if (state_q == INSTR) begin
        complete_instr_d = 1'b1;
        instr_dout_d     = ack_done ? mem_rdata : '0;
      end else begin
        complete_data_d = 1'b1;
        // mem_we_q still records whether the granted data access was a write.
        if (expire)         data_dout_d = '0;
        else if (!mem_we_q) data_dout_d = mem_rdata;
      end
    end
  end

  assign Instr_dout     = instr_dout_q;
  assign Data_dout      = data_dout_q;
  assign complete_instr = complete_instr_q;
  assign complete_data  = complete_data_q;
  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed scenarios plus randomized request/ack
// traffic checked against a transaction-level arbitration model.
module tb_lc3_mem_arbiter;

  localparam int SM = 4;
  localparam int TO = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int starve = 0;
  logic [15:0] exp_idout = '0;
  logic [15:0] exp_ddout = '0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr),
    .Data_din(Data_din), .Data_dout(Data_dout), .complete_data(complete_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_cinstr"}, complete_instr, 0);
    chk({tag, "_cdata"}, complete_data, 0);
    chk({tag, "_buserr"}, bus_err, 0);
    chk({tag, "_memen"}, mem_en, 0);
  endtask

  // Runs one access from an IDLE cycle with the current request inputs.
  // dly < 0: never ack (timeout); otherwise ack dly cycles after mem_en rises.
  task automatic access(input int dly, input logic [15:0] rdv, output bit was_data);
    logic [15:0] a, w;
    bit we, timed;
    int n;
    was_data = data_req && !(instrmem_rd && starve == SM);
    if (was_data) starve = instrmem_rd ? ((starve < SM) ? starve + 1 : starve) : 0;
    else          starve = 0;
    a  = was_data ? Data_addr : pc;
    we = was_data && !Data_rd;
    w  = Data_din;
    timed = (dly < 0);
    n  = timed ? TO : dly + 1;
    step();
    for (int k = 0; k < n; k++) begin
      chk("busy_memen", mem_en, 1);
      chk("busy_addr", mem_addr, a);
      chk("busy_we", mem_we, we);
      if (we) chk("busy_wdata", mem_wdata, w);
      chk("busy_nocomplete", {complete_instr, complete_data, bus_err}, 0);
      Data_addr = 16'($urandom);
      Data_din  = 16'($urandom);
      Data_rd   = 1'($urandom);
      pc        = 16'($urandom);
      mem_ack   = (!timed && k == dly);
      mem_rdata = mem_ack ? rdv : 16'($urandom);
      step();
    end
    mem_ack = 1'b0;
    if (was_data) begin
      chk("cdata", complete_data, 1);
      chk("cinstr_excl", complete_instr, 0);
      if (timed) exp_ddout = '0;
      else if (!we) exp_ddout = rdv;
    end else begin
      chk("cinstr", complete_instr, 1);
      chk("cdata_excl", complete_data, 0);
      exp_idout = timed ? 16'h0 : rdv;
    end
    chk("data_dout", Data_dout, exp_ddout);
    chk("instr_dout", Instr_dout, exp_idout);
    chk("bus_err", bus_err, timed);
    chk("done_memen", mem_en, 0);
    chk("done_memwe", mem_we, 0);
  endtask

  bit wd;
  int nd;

  initial begin
    reset = 1'b1;
    pc = '0; instrmem_rd = 0; data_req = 0; Data_rd = 0;
    Data_addr = '0; Data_din = '0; mem_rdata = '0; mem_ack = 0;
    step();
    step();
    quiet("rst");
    chk("rst_idout", Instr_dout, 0);
    chk("rst_ddout", Data_dout, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", mem_we, 0);
    reset = 1'b0;
    step();
    quiet("post_rst");

    // Fetch only
    pc = 16'h3000; instrmem_rd = 1;
    access(2, 16'h1234, wd);
    chk("t1_port", wd, 0);
    chk("t1_idout", Instr_dout, 16'h1234);
    instrmem_rd = 0;
    step();
    quiet("t1_after");

    // Write then read back-to-back
    data_req = 1; Data_rd = 0; Data_addr = 16'h3100; Data_din = 16'hBEEF;
    access(0, 16'h5555, wd);
    chk("t2w_ddout_unchanged", Data_dout, 16'h0);
    Data_rd = 1; Data_addr = 16'h3100;
    access(1, 16'hBEEF, wd);
    chk("t2r_ddout", Data_dout, 16'hBEEF);
    data_req = 0;
    step();
    quiet("t2_after");

    // Simultaneous requests
    data_req = 1; instrmem_rd = 1; Data_rd = 1; Data_addr = 16'h0040; pc = 16'h0100;
    access(0, 16'hA5A5, wd);
    chk("t3_first_data", wd, 1);
    data_req = 0;
    access(1, 16'h5A5A, wd);
    chk("t3_second_instr", wd, 0);
    instrmem_rd = 0;
    step();
    quiet("t3_after");

    // Starvation: both requests held continuously
    data_req = 1; instrmem_rd = 1;
    for (int i = 0; i < 15; i++) begin
      access($urandom_range(0, 2), 16'($urandom), wd);
      chk("t4_pattern", wd, (i % 5) != 4);
    end
    data_req = 0; instrmem_rd = 0;
    step();
    quiet("t4_after");
    starve = 0;

    // Timeout on a data read, then ack arriving exactly at expiry
    data_req = 1; Data_rd = 1; Data_addr = 16'h2222;
    access(-1, 16'h0, wd);
    chk("t5_dout_zero", Data_dout, 0);
    data_req = 0;
    step();
    quiet("t5_idle");
    instrmem_rd = 1; pc = 16'h4444;
    access(TO - 1, 16'hC0DE, wd);
    chk("t5_ack_wins_idout", Instr_dout, 16'hC0DE);
    instrmem_rd = 0;
    step();
    quiet("t5b_idle");

    // Reset in the middle of a data access
    data_req = 1; Data_rd = 0; Data_addr = 16'h0777; Data_din = 16'h1111;
    step();
    step();
    chk("t6_pre_memen", mem_en, 1);
    reset = 1'b1;
    #1;
    quiet("t6_rst");
    chk("t6_idout", Instr_dout, 0);
    chk("t6_ddout", Data_dout, 0);
    chk("t6_addr", mem_addr, 0);
    data_req = 0;
    step();
    reset = 1'b0;
    mem_ack = 1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 0;
    quiet("t6_stale_ack");
    chk("t6_stale_ddout", Data_dout, 0);
    exp_idout = '0; exp_ddout = '0; starve = 0;

    // Randomized traffic
    for (int r = 0; r < 250; r++) begin
      if (!data_req && !instrmem_rd) begin
        data_req    = ($urandom_range(0, 2) == 0);
        instrmem_rd = ($urandom_range(0, 2) == 0);
      end
      Data_rd   = 1'($urandom);
      Data_addr = 16'($urandom);
      Data_din  = 16'($urandom);
      pc        = 16'($urandom);
      if (!data_req && !instrmem_rd) begin
        mem_ack   = 1'($urandom);
        mem_rdata = 16'($urandom);
        step();
        mem_ack = 0;
        starve  = 0;
        quiet("rnd_idle");
        chk("rnd_idle_ddout", Data_dout, exp_ddout);
        chk("rnd_idle_idout", Instr_dout, exp_idout);
      end else begin
        access($urandom_range(0, 3), 16'($urandom), wd);
        if (wd) data_req    = 1'($urandom);
        else    instrmem_rd = 1'($urandom);
        if (!data_req && $urandom_range(0, 2) == 0) data_req = 1;
        if (!instrmem_rd && $urandom_range(0, 2) == 0) instrmem_rd = 1;
      end
    end
    data_req = 0; instrmem_rd = 0;
    step();
    quiet("final");

    nd = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
